keycode_decoder: RTL
====================

KEYCODE_DECODER -- requirements
Module: keycode_decoder

Interface
REQ-001 SHALL have parameter KEY_UP, default 8'h1A (W), meaning the Player_Up keycode.
REQ-002 SHALL have parameter KEY_LEFT, default 8'h04 (A), meaning the Player_Left keycode.
REQ-003 SHALL have parameter KEY_RIGHT, default 8'h07 (D), meaning the Player_Right keycode.
REQ-004 SHALL have parameter KEY_SHOOT, default 8'h2C (Space), meaning the shoot keycode.
REQ-005 SHALL have parameter KEY_FIGHT, default 8'h28 (Enter), meaning the fight/start keycode.
REQ-006 SHALL have parameter SHOOT_COOLDOWN, default 16, range 1..255, meaning the number of frames between shots.
REQ-007 SHALL have port Clk, input, 1 bit: the 50 MHz system clock; the only clock.
REQ-008 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port frame_clk, input, 1 bit: VGA_VS, asynchronous to Clk, sampled as data.
REQ-010 SHALL have port keycode, input, 8 bits: USB HID keycode written by the NIOS PIO; 8'h00 means no key.
REQ-011 SHALL have ports Up, Left and Right, each an output of 1 bit: level controls, held for a whole frame.
REQ-012 SHALL have port Shoot, output, 1 bit: one-Clk-cycle fire pulse.
REQ-013 SHALL have port Fight, output, 1 bit: one-Clk-cycle pulse on a new KEY_FIGHT press.
REQ-014 SHALL have port cooldown_active, output, 1 bit: high while a shot is locked out.

Function
REQ-015 SHALL pass keycode and frame_clk each through a two-flop synchronizer in Clk.
REQ-016 SHALL assert an internal frame_tick for exactly one Clk cycle on each synchronized frame_clk 0->1 edge.
REQ-017 SHALL, on frame_tick, latch the synchronized keycode into key_frame; all decoding uses key_frame only.
REQ-018 SHALL register Up, Left and Right to (key_frame == KEY_x), updated only on the cycle after the latch.
REQ-019 SHALL give a latency of 2 sync cycles + wait for the next frame_tick + 2 cycles from a keycode change to a level output change.
REQ-020 SHALL never assert Left and Right together (single-keycode input; guaranteed by construction).
REQ-021 SHALL raise Fight for one Clk cycle when key_frame becomes KEY_FIGHT and the previous key_frame was not KEY_FIGHT; holding the key gives no repeat.
REQ-022 SHALL run a shoot FSM with states IDLE, FIRE, COOLDOWN and WAIT_RELEASE.
REQ-023 SHALL, in IDLE, go to FIRE on a frame_tick-updated key_frame == KEY_SHOOT.
REQ-024 SHALL, in FIRE, assert Shoot for one cycle, load the 8-bit counter with SHOOT_COOLDOWN-1, and go to COOLDOWN.
REQ-025 SHALL, in COOLDOWN, decrement the counter once per frame_tick.
REQ-026 SHALL, in COOLDOWN at counter == 0 on a frame_tick, go to WAIT_RELEASE if key_frame == KEY_SHOOT, else to IDLE.
REQ-027 SHALL, in WAIT_RELEASE, go to IDLE on the first frame where key_frame != KEY_SHOOT; holding the key never auto-fires.
REQ-028 SHALL drive cooldown_active = 1 in the FIRE, COOLDOWN and WAIT_RELEASE states.
REQ-029 SHALL apply every state change at most once per frame, except FIRE->COOLDOWN, which is immediate on the next Clk.
REQ-030 SHALL ignore keycode values that match no parameter: levels go 0, and the FSM treats the value as released.
REQ-031 SHALL, if frame_clk stops toggling, hold all outputs at their last state and leave Shoot and Fight deasserted.

Reset
REQ-032 SHALL, on Reset high at a Clk edge, clear Up, Left, Right, Shoot, Fight and cooldown_active to 0.
REQ-033 SHALL, on that reset edge, put the FSM in IDLE, clear the counter and key_frame to 8'h00, and clear the sync flops to 0.
REQ-034 SHALL let Reset mid-COOLDOWN or mid-WAIT_RELEASE return to IDLE.
REQ-035 SHALL treat a key held through Reset as a new press at the first frame_tick after reset, so Shoot or Fight fires once.
REQ-036 SHALL give Reset priority over frame_tick in the same cycle.

Verification
REQ-037 SHALL cover: keycode=8'h07 steady, 3 frames -> Right=1 from the 1st tick+2 cycles, Left=Up=0, Shoot never 1.
REQ-038 SHALL cover: keycode=8'h2C held 40 frames, SHOOT_COOLDOWN=16 -> exactly one Shoot pulse of width 1, then cooldown_active=1 through release.
REQ-039 SHALL cover: Space pressed and released every 2 frames for 40 frames -> Shoot pulses spaced >= 16 frames apart, 3 pulses total.
REQ-040 SHALL cover: keycode=8'h28 held 10 frames -> one Fight pulse; release, then repress -> a second pulse.
REQ-041 SHALL cover: keycode change to 8'h1A for 1 Clk cycle between frame edges -> Up stays 0.
REQ-042 SHALL cover: Reset asserted in COOLDOWN with Space held -> outputs 0 next cycle; Shoot re-fires at the first tick after reset.

Source files
------------

// File: rtl/keycode_decoder.sv
// Frame-synchronous keyboard decoder: turns a raw HID keycode into per-frame
// movement levels, a rate-limited shoot pulse and a start/fight pulse.
module keycode_decoder #(
  parameter logic [7:0]  KEY_UP         = 8'h1A,
  parameter logic [7:0]  KEY_LEFT       = 8'h04,
  parameter logic [7:0]  KEY_RIGHT      = 8'h07,
  parameter logic [7:0]  KEY_SHOOT      = 8'h2C,
  parameter logic [7:0]  KEY_FIGHT      = 8'h28,
  parameter int unsigned SHOOT_COOLDOWN = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic       Up,
  output logic       Left,
  output logic       Right,
  output logic       Shoot,
  output logic       Fight,
  output logic       cooldown_active
);

  typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN, WAIT_RELEASE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SHOOT_COOLDOWN - 1);

  logic [7:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic       fc_s1_q, fc_s1_d, fc_s2_q, fc_s2_d, fc_s3_q, fc_s3_d;
  logic [7:0] key_frame_q, key_frame_d, prev_frame_q, prev_frame_d;
  logic       upd_q, upd_d;
  logic       up_q, up_d, left_q, left_d, right_q, right_d, fight_q, fight_d;
  logic [7:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic       frame_tick;
  logic       shoot_held;

  assign frame_tick = fc_s2_q & ~fc_s3_q;
  assign shoot_held = (key_frame_q == KEY_SHOOT);

  // upd_q marks the single cycle in which key_frame_q holds this frame's fresh value
  always_comb begin
    key_s1_d     = keycode;
    key_s2_d     = key_s1_q;
    fc_s1_d      = frame_clk;
    fc_s2_d      = fc_s1_q;
    fc_s3_d      = fc_s2_q;
    key_frame_d  = key_frame_q;
    prev_frame_d = prev_frame_q;
    upd_d        = frame_tick;
    up_d         = up_q;
    left_d       = left_q;
    right_d      = right_q;
    fight_d      = 1'b0;
    if (frame_tick) begin
      key_frame_d  = key_s2_q;
      prev_frame_d = key_frame_q;
    end
    if (upd_q) begin
      up_d    = (key_frame_q == KEY_UP);
      left_d  = (key_frame_q == KEY_LEFT);
      right_d = (key_frame_q == KEY_RIGHT);
      fight_d = (key_frame_q == KEY_FIGHT) && (prev_frame_q != KEY_FIGHT);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (upd_q && shoot_held) state_d = FIRE;
      end
      FIRE: begin
        cnt_d   = CNT_LOAD;
        state_d = COOLDOWN;
      end
      COOLDOWN: begin
        if (upd_q) begin
          if (cnt_q == 8'd0) state_d = shoot_held ? WAIT_RELEASE : IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      WAIT_RELEASE: begin
        if (upd_q && !shoot_held) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_s1_q     <= 8'h00;
      key_s2_q     <= 8'h00;
      fc_s1_q      <= 1'b0;
      fc_s2_q      <= 1'b0;
      fc_s3_q      <= 1'b0;
      key_frame_q  <= 8'h00;
      prev_frame_q <= 8'h00;
      upd_q        <= 1'b0;
      up_q         <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      fight_q      <= 1'b0;
      cnt_q        <= 8'h00;
      state_q      <= IDLE;
    end else begin
      key_s1_q     <= key_s1_d;
      key_s2_q     <= key_s2_d;
      fc_s1_q      <= fc_s1_d;
      fc_s2_q      <= fc_s2_d;
      fc_s3_q      <= fc_s3_d;
      key_frame_q  <= key_frame_d;
      prev_frame_q <= prev_frame_d;
      upd_q        <= upd_d;
      up_q         <= up_d;
      left_q       <= left_d;
      right_q      <= right_d;
      fight_q      <= fight_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
    end
  end

  assign Up              = up_q;
  assign Left            = left_q;
  assign Right           = right_q;
  assign Fight           = fight_q;
  assign Shoot           = (state_q == FIRE);
  assign cooldown_active = (state_q != IDLE);

endmodule
